// File: rtl/spi_telemetry_tx.sv
// spi_telemetry_tx: SPI mode-0 peripheral transmitter for the game-status frame.
// Oversamples the asynchronous sck/ce pins on clk, snapshots frame_data when
// ce rises and shifts the snapshot out MSB-first on sdo. Bytes requested past
// the end of the frame read as FILL_BYTE and raise the sticky overrun flag.
//
// Optional feature: define SPI_TX_CHECKSUM_EN to append one extra frame byte
// holding the XOR of all snapshot payload bytes.
//
// Handshake: there is no valid/ready pair here. The MCU owns the pace through
// sck/ce, snapshot and tx_done are single-cycle strobes, and bytes_sent,
// partial and overrun are level outputs that hold until they are next updated.
// state_dbg exposes the FSM state (0 = IDLE, 1 = ACTIVE).
module spi_telemetry_tx #(
   parameter int         NUM_BYTES = 4,
   parameter logic [7:0] FILL_BYTE = 8'h00
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sck,
   input  logic                   ce,
   input  logic [NUM_BYTES*8-1:0] frame_data,
   output logic                   sdo,
   output logic                   busy,
   output logic                   snapshot,
   output logic                   tx_done,
   output logic [7:0]             bytes_sent,
   output logic                   partial,
   output logic                   overrun,
   output logic                   state_dbg
);

`ifdef SPI_TX_CHECKSUM_EN
   localparam int FRAME_BYTES = NUM_BYTES + 1;
`else
   localparam int FRAME_BYTES = NUM_BYTES;
`endif
   // Byte index reaches at most 17 (16 payload bytes + checksum).
   localparam int                IDX_W      = 5;
   localparam logic [IDX_W-1:0]  FRAME_LAST = IDX_W'(FRAME_BYTES);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t state, state_n;

   logic ce_s1, ce_s2, ce_h;
   logic sck_s1, sck_s2, sck_h;
   logic ce_rise, ce_fall, sck_rise, sck_fall;

   logic [NUM_BYTES*8-1:0] snap_q, snap_n;
   logic [7:0]             shift_q, shift_n;
   logic [2:0]             bit_cnt, bit_cnt_n;
   logic [IDX_W-1:0]       byte_idx, byte_idx_n, idx_inc;
   logic [7:0]             rx_bytes, rx_bytes_n;
   logic [7:0]             load_byte;
   logic                   sdo_n, snapshot_n, tx_done_n, partial_n, overrun_n;
   logic [7:0]             bytes_sent_n;

   // Pin synchronizers plus history flops; ce resets high so a ce already
   // high at reset release does not look like a new transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         ce_s1  <= 1'b1;
         ce_s2  <= 1'b1;
         ce_h   <= 1'b1;
         sck_s1 <= 1'b0;
         sck_s2 <= 1'b0;
         sck_h  <= 1'b0;
      end else begin
         ce_s1  <= ce;
         ce_s2  <= ce_s1;
         ce_h   <= ce_s2;
         sck_s1 <= sck;
         sck_s2 <= sck_s1;
         sck_h  <= sck_s2;
      end
   end

   assign ce_rise  =  ce_s2  & ~ce_h;
   assign ce_fall  = ~ce_s2  &  ce_h;
   assign sck_rise =  sck_s2 & ~sck_h;
   assign sck_fall = ~sck_s2 &  sck_h;

   assign idx_inc = (byte_idx < FRAME_LAST) ? byte_idx + IDX_W'(1) : byte_idx;

`ifdef SPI_TX_CHECKSUM_EN
   logic [7:0] checksum;

   // XOR of every payload byte, taken from the snapshot so it matches sdo.
   always_comb begin
      checksum = 8'h00;
      for (int i = 0; i < NUM_BYTES; i++) begin
         checksum = checksum ^ snap_q[i*8 +: 8];
      end
   end
`endif

   // Next byte to present at a byte boundary; anything past the frame is fill.
   always_comb begin
      load_byte = FILL_BYTE;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (idx_inc == IDX_W'(i)) begin
            load_byte = snap_q[(NUM_BYTES-1-i)*8 +: 8];
         end
      end
`ifdef SPI_TX_CHECKSUM_EN
      if (idx_inc == IDX_W'(NUM_BYTES)) begin
         load_byte = checksum;
      end
`endif
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         snap_q     <= '0;
         shift_q    <= 8'h00;
         bit_cnt    <= 3'd0;
         byte_idx   <= '0;
         rx_bytes   <= 8'h00;
         sdo        <= 1'b0;
         snapshot   <= 1'b0;
         tx_done    <= 1'b0;
         bytes_sent <= 8'h00;
         partial    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_n;
         snap_q     <= snap_n;
         shift_q    <= shift_n;
         bit_cnt    <= bit_cnt_n;
         byte_idx   <= byte_idx_n;
         rx_bytes   <= rx_bytes_n;
         sdo        <= sdo_n;
         snapshot   <= snapshot_n;
         tx_done    <= tx_done_n;
         bytes_sent <= bytes_sent_n;
         partial    <= partial_n;
         overrun    <= overrun_n;
      end
   end

   // Next-state and output logic; a ce edge always beats an sck edge.
   always_comb begin
      state_n      = state;
      snap_n       = snap_q;
      shift_n      = shift_q;
      bit_cnt_n    = bit_cnt;
      byte_idx_n   = byte_idx;
      rx_bytes_n   = rx_bytes;
      sdo_n        = sdo;
      snapshot_n   = 1'b0;
      tx_done_n    = 1'b0;
      bytes_sent_n = bytes_sent;
      partial_n    = partial;
      overrun_n    = overrun;

      case (state)
         IDLE: begin
            sdo_n = 1'b0;
            if (ce_rise) begin
               snap_n     = frame_data;
               snapshot_n = 1'b1;
               shift_n    = frame_data[NUM_BYTES*8-1 -: 8];
               sdo_n      = frame_data[NUM_BYTES*8-1];
               bit_cnt_n  = 3'd0;
               byte_idx_n = '0;
               rx_bytes_n = 8'h00;
               overrun_n  = 1'b0;
               state_n    = ACTIVE;
            end
         end
         ACTIVE: begin
            if (ce_fall) begin
               tx_done_n    = 1'b1;
               bytes_sent_n = rx_bytes;
               partial_n    = (bit_cnt != 3'd0);
               sdo_n        = 1'b0;
               state_n      = IDLE;
            end else if (sck_rise) begin
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7 && rx_bytes != 8'hFF) begin
                  rx_bytes_n = rx_bytes + 8'd1;
               end
            end else if (sck_fall) begin
               if (bit_cnt != 3'd0) begin
                  shift_n = {shift_q[6:0], 1'b0};
                  sdo_n   = shift_q[6];
               end else begin
                  byte_idx_n = idx_inc;
                  shift_n    = load_byte;
                  sdo_n      = load_byte[7];
                  if (idx_inc >= FRAME_LAST) begin
                     overrun_n = 1'b1;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy      = (state == ACTIVE);
   assign state_dbg = state;

endmodule

// File: tb/tb_spi_telemetry_tx.sv
// tb_spi_telemetry_tx: drives an MCU-side SPI mode-0 master against
// spi_telemetry_tx and checks the bytes it reads against a frame model.
module tb_spi_telemetry_tx;

   localparam int         NB   = 4;
   localparam logic [7:0] FILL = 8'h00;
`ifdef SPI_TX_CHECKSUM_EN
   localparam int FB = NB + 1;
`else
   localparam int FB = NB;
`endif

   logic          clk;
   logic          reset;
   logic          sck;
   logic          ce;
   logic [NB*8-1:0] frame_data;
   logic          sdo;
   logic          busy;
   logic          snapshot;
   logic          tx_done;
   logic [7:0]    bytes_sent;
   logic          partial;
   logic          overrun;
   logic          state_dbg;

   int n_cmp;
   int n_bad;
   logic [7:0] exp_q[$];

   spi_telemetry_tx #(.NUM_BYTES(NB), .FILL_BYTE(FILL)) dut (
      .clk        (clk),
      .reset      (reset),
      .sck        (sck),
      .ce         (ce),
      .frame_data (frame_data),
      .sdo        (sdo),
      .busy       (busy),
      .snapshot   (snapshot),
      .tx_done    (tx_done),
      .bytes_sent (bytes_sent),
      .partial    (partial),
      .overrun    (overrun),
      .state_dbg  (state_dbg)
   );

   // Clock and reset defaults.
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Byte j of the frame as the MCU should see it: payload, optional XOR
   // checksum, then fill for ever.
   function automatic logic [7:0] model_byte(input logic [NB*8-1:0] fd, input int j);
      logic [7:0] x;
      x = 8'h00;
      if (j < NB) return fd[(NB-1-j)*8 +: 8];
      for (int i = 0; i < NB; i++) x = x ^ fd[i*8 +: 8];
      if (j < FB) return x;
      return FILL;
   endfunction

   // Raise ce, wait for the snapshot strobe and check it.
   task automatic start_frame(input logic [NB*8-1:0] fd, input bit corrupt, input string tag);
      int t;
      frame_data = fd;
      @(negedge clk);
      ce = 1'b1;
      t = 0;
      while (snapshot !== 1'b1 && t < 10) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (snapshot !== 1'b1) begin
         n_bad++;
         $display("FAIL %s snapshot_timeout: got %b want 1", tag, snapshot);
      end else begin
         n_cmp++;
         if (busy !== 1'b1 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL %s snapshot_state: got busy=%b overrun=%b want busy=1 overrun=0", tag, busy, overrun);
         end
         @(negedge clk);
         n_cmp++;
         if (snapshot !== 1'b0) begin
            n_bad++;
            $display("FAIL %s snapshot_width: got %b want 0", tag, snapshot);
         end
         if (corrupt) frame_data = '1;
      end
      repeat (4) @(negedge clk);
   endtask

   // Clock nbits bits as an SPI mode-0 master. The last bit leaves sck high
   // while ce drops, then sck returns to idle.
   task automatic clock_bits(input int nbits, input int half, input logic [NB*8-1:0] fd,
                             input bit end_ce, input string tag);
      logic [7:0] got;
      logic [7:0] want;
      int nbytes;
      int t;
      int exp_sent;
      got = 8'h00;
      nbytes = (nbits + 7) / 8;
      for (int j = 0; j < nbytes; j++) exp_q.push_back(model_byte(fd, j));
      for (int k = 0; k < nbits; k++) begin
         repeat (half) @(negedge clk);
         if (k % 8 == 0) begin
            n_cmp++;
            if (overrun !== ((k / 8) >= FB)) begin
               n_bad++;
               $display("FAIL %s overrun_byte%0d: got %b want %b", tag, k / 8, overrun, (k / 8) >= FB);
            end
         end
         got = {got[6:0], sdo};
         sck = 1'b1;
         if (k % 8 == 7 || k == nbits - 1) begin
            want = exp_q.pop_front();
            if (k % 8 != 7) want = want >> (7 - (k % 8));
            n_cmp++;
            if (got !== want) begin
               n_bad++;
               $display("FAIL %s byte%0d: got %02h want %02h", tag, k / 8, got, want);
            end
            got = 8'h00;
         end
         repeat (half) @(negedge clk);
         if (k != nbits - 1 || !end_ce) sck = 1'b0;
      end
      if (end_ce) begin
         ce = 1'b0;
         t = 0;
         while (tx_done !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
         end
         exp_sent = (nbits / 8 > 255) ? 255 : nbits / 8;
         n_cmp++;
         if (tx_done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s tx_done_timeout: got %b want 1", tag, tx_done);
         end else begin
            n_cmp++;
            if (bytes_sent !== 8'(exp_sent) || partial !== (nbits % 8 != 0) ||
                overrun !== ((nbits - 1) >= 8 * FB) || busy !== 1'b0) begin
               n_bad++;
               $display("FAIL %s end_status: got sent=%0d partial=%b overrun=%b busy=%b want sent=%0d partial=%b overrun=%b busy=0",
                        tag, bytes_sent, partial, overrun, busy, exp_sent, (nbits % 8 != 0), ((nbits - 1) >= 8 * FB));
            end
            @(negedge clk);
            n_cmp++;
            if (tx_done !== 1'b0 || sdo !== 1'b0 || bytes_sent !== 8'(exp_sent)) begin
               n_bad++;
               $display("FAIL %s after_done: got tx_done=%b sdo=%b sent=%0d want 0 0 %0d",
                        tag, tx_done, sdo, bytes_sent, exp_sent);
            end
         end
         sck = 1'b0;
         repeat (6) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ce = 1'b0;
      sck = 1'b0;
      frame_data = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({sdo, busy, snapshot, tx_done, partial, overrun} !== 6'b0 || bytes_sent !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_outputs: got sdo=%b busy=%b snap=%b done=%b partial=%b ovr=%b sent=%0d want all 0",
                  sdo, busy, snapshot, tx_done, partial, overrun, bytes_sent);
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_four_byte();
      start_frame(32'hA53C_0F81, 1'b0, "four_byte");
      clock_bits(32, 6, 32'hA53C_0F81, 1'b1, "four_byte");
   endtask

   task automatic test_six_byte();
      start_frame(32'hA53C_0F81, 1'b0, "six_byte");
      clock_bits(48, 6, 32'hA53C_0F81, 1'b1, "six_byte");
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_bad++;
         $display("FAIL six_byte overrun_sticky: got %b want 1", overrun);
      end
   endtask

   task automatic test_partial();
      start_frame(32'hA53C_0F81, 1'b0, "partial");
      clock_bits(12, 6, 32'hA53C_0F81, 1'b1, "partial");
   endtask

   task automatic test_snapshot_isolation();
      start_frame(32'hA53C_0F81, 1'b1, "isolation");
      clock_bits(32, 6, 32'hA53C_0F81, 1'b1, "isolation");
   endtask

   task automatic test_reset_mid_frame();
      bit saw_bad;
      start_frame(32'hA53C_0F81, 1'b0, "reset_mid");
      clock_bits(12, 6, 32'hA53C_0F81, 1'b0, "reset_mid");
      exp_q.delete();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({sdo, busy, snapshot, tx_done, partial, overrun} !== 6'b0 || bytes_sent !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_mid outputs: got sdo=%b busy=%b snap=%b done=%b partial=%b ovr=%b sent=%0d want all 0",
                  sdo, busy, snapshot, tx_done, partial, overrun, bytes_sent);
      end
      reset = 1'b0;
      saw_bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i % 6 == 0) sck = ~sck;
         @(negedge clk);
         if (snapshot !== 1'b0 || busy !== 1'b0 || sdo !== 1'b0) saw_bad = 1'b1;
      end
      sck = 1'b0;
      n_cmp++;
      if (saw_bad !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid no_restart: got activity=%b want 0", saw_bad);
      end
      ce = 1'b0;
      repeat (8) @(negedge clk);
      start_frame(32'h1234_5678, 1'b0, "after_reset");
      clock_bits(32, 6, 32'h1234_5678, 1'b1, "after_reset");
   endtask

   task automatic test_random();
      logic [NB*8-1:0] fd;
      int nbits;
      int half;
      for (int r = 0; r < 6; r++) begin
         fd = $urandom;
         nbits = $urandom_range(60, 1);
         half = $urandom_range(8, 4);
         start_frame(fd, r[0], $sformatf("random%0d", r));
         clock_bits(nbits, half, fd, 1'b1, $sformatf("random%0d", r));
      end
   endtask

   task automatic test_saturation();
      logic [NB*8-1:0] fd;
      fd = $urandom;
      start_frame(fd, 1'b0, "saturate");
      clock_bits(256 * 8 + 3, 4, fd, 1'b1, "saturate");
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_four_byte();
      test_six_byte();
      test_partial();
      test_snapshot_isolation();
      test_reset_mid_frame();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
